// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store controller.
// Holds the funct3 size codes, the FSM state type and the alignment check helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  // Halfwords need an even address and words need a 4-byte-aligned address.
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_H, F3_HU: bad = addr_lo[0];
      F3_W:        bad = (addr_lo != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Combinational lane logic: extends load data out of the RAM word and merges
// sub-word store data into the old RAM word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] spo,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = spo[8*addr_lo +: 8];
    half_sel = addr_lo[1] ? spo[31:16] : spo[15:0];
  end

  always_comb begin
    load_data = 32'h0;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      F3_W:    load_data = spo;
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    store_data = spo;
    case (funct3)
      F3_B:    store_data[8*addr_lo +: 8] = wdata[7:0];
      F3_H:    begin
        if (addr_lo[1]) store_data[31:16] = wdata[15:0];
        else            store_data[15:0]  = wdata[15:0];
      end
      F3_W:    store_data = wdata;
      default: store_data = spo;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller driving the word-wide data_ram port.
// Three-state FSM: accept in IDLE, touch RAM for one ACCESS cycle, present the response in RESP.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned SIZE_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        ram_we,
  output logic [31:0] ram_a,
  output logic [31:0] ram_d,
  input  logic [31:0] ram_spo,
  output lsu_state_t  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid without ready is ignored, and resp_valid holds with stable data until resp_ready.

  lsu_state_t  state, state_next;
  logic        run;
  logic        lat_we;
  logic [2:0]  lat_f3;
  logic [31:0] lat_off;
  logic [1:0]  lat_lo;
  logic [31:0] lat_wdata;
  logic        lat_err;
  logic [31:0] req_off;
  logic        req_bad_f3;
  logic        req_err;
  logic        accept;
  logic [31:0] load_data;
  logic [31:0] store_data;

  // Offset wraps for addresses below the base, so one unsigned compare covers both ends.
  always_comb begin
    req_off    = req_addr - BASE_ADDR;
    req_bad_f3 = req_we ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                        : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
    req_err    = req_bad_f3 || misaligned(req_funct3, req_addr[1:0]) ||
                 (req_off >= SIZE_BYTES);
  end

  // run keeps req_ready low during reset even though the state register sits at IDLE.
  assign req_ready  = run && (state == IDLE);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == RESP);
  assign dbg_state  = state;

  always_comb begin
    state_next = state;
    ram_we     = 1'b0;
    ram_d      = lat_wdata;
    case (state)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS: begin
        ram_we     = lat_we && !lat_err;
        ram_d      = store_data;
        state_next = RESP;
      end
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ram_a = {2'b00, lat_off[31:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      run   <= 1'b0;
    end else begin
      state <= state_next;
      run   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we    <= 1'b0;
      lat_f3    <= 3'b000;
      lat_off   <= 32'h0;
      lat_lo    <= 2'b00;
      lat_wdata <= 32'h0;
      lat_err   <= 1'b0;
    end else if (accept) begin
      lat_we    <= req_we;
      lat_f3    <= req_funct3;
      lat_off   <= req_off;
      lat_lo    <= req_addr[1:0];
      lat_wdata <= req_wdata;
      lat_err   <= req_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else if (state == ACCESS) begin
      resp_rdata <= (lat_err || lat_we) ? 32'h0 : load_data;
      resp_err   <= lat_err;
    end
  end

  lsu_align u_align (
    .funct3     (lat_f3),
    .addr_lo    (lat_lo),
    .spo        (ram_spo),
    .wdata      (lat_wdata),
    .load_data  (load_data),
    .store_data (store_data)
  );

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural data_ram and an expected-response queue.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        ram_we;
  logic [31:0] ram_a, ram_d, ram_spo;
  lsu_state_t  dbg_state;

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [2:0]  b_req_funct3;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_resp_rdata;
  logic        b_ram_we;
  logic [31:0] b_ram_a, b_ram_d;
  lsu_state_t  b_dbg_state;

  logic [31:0] mem [256];
  logic        pl_we;
  logic [7:0]  pl_idx;
  logic [31:0] pl_val;
  logic [32:0] exp_q[$];
  int          n_chk, n_fail, we_cnt;
  logic [31:0] last_d;

  lsu_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .ram_we(ram_we), .ram_a(ram_a), .ram_d(ram_d),
    .ram_spo(ram_spo), .dbg_state(dbg_state)
  );

  lsu_mem_ctrl #(.BASE_ADDR(32'h0000_1000), .SIZE_BYTES(1024)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_funct3(b_req_funct3), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .ram_we(b_ram_we),
    .ram_a(b_ram_a), .ram_d(b_ram_d), .ram_spo(32'h0BAD_F00D), .dbg_state(b_dbg_state)
  );

  // clock / RAM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_spo = mem[ram_a[7:0]];
  always @(posedge clk) begin
    if (ram_we) mem[ram_a[7:0]] <= ram_d;
    else if (pl_we) mem[pl_idx] <= pl_val;
  end

  always @(negedge clk) begin
    if (ram_we) begin
      we_cnt = we_cnt + 1;
      last_d = ram_d;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_we = 1'b1; pl_idx = idx; pl_val = val;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Returns #1 after the accepting edge, i.e. during the ACCESS cycle.
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic push,
                      input logic exp_err, input logic [31:0] exp_rdata);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (push) exp_q.push_back({exp_err, exp_rdata});
  endtask

  task automatic recv(input string tag, input int hold, input logic pulse);
    logic [32:0] e;
    logic [31:0] d0;
    int n;
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd1);
    d0 = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (pulse && i == 1) begin
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W;
        req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;
      end
      chk({tag, "_hold_valid"}, {31'h0, resp_valid}, 32'h1);
      chk({tag, "_hold_data"}, resp_rdata, d0);
      chk({tag, "_hold_req_ready"}, {31'h0, req_ready}, 32'h0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'h1, 32'h0 + 32'(exp_q.size()));
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    chk({tag, "_valid"}, {31'h0, resp_valid}, 32'h1);
    chk({tag, "_rdata"}, resp_rdata, e[31:0]);
    chk({tag, "_err"}, {31'h0, resp_err}, {31'h0, e[32]});
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'h0, resp_valid}, 32'h0);
  endtask

  task automatic b_access(input string tag, input logic [31:0] addr, input logic exp_err,
                          input logic [31:0] exp_a, input logic [31:0] exp_rdata);
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_funct3 = F3_W; b_req_addr = addr;
    chk({tag, "_ready"}, {31'h0, b_req_ready}, 32'h1);
    @(posedge clk);
    #1 b_req_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_ram_a"}, b_ram_a, exp_a);
    chk({tag, "_ram_we"}, {31'h0, b_ram_we}, 32'h0);
    @(negedge clk);
    chk({tag, "_valid"}, {31'h0, b_resp_valid}, 32'h1);
    chk({tag, "_err"}, {31'h0, b_resp_err}, {31'h0, exp_err});
    chk({tag, "_rdata"}, b_resp_rdata, exp_rdata);
    b_resp_ready = 1'b1;
    @(posedge clk);
    #1 b_resp_ready = 1'b0;
  endtask

  initial begin
    int w0;
    n_chk = 0; n_fail = 0; we_cnt = 0; last_d = '0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_funct3 = 3'b0;
    b_req_addr = '0; b_req_wdata = '0; b_resp_ready = 1'b0;
    pl_we = 1'b0; pl_idx = '0; pl_val = '0;

    // reset values
    #3;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_ram_we", {31'h0, ram_we}, 32'h0);
    chk("rst_ram_a", ram_a, 32'h0);
    chk("rst_ram_d", ram_d, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("post_rst_state", 32'(dbg_state), 32'(IDLE));

    preload(8'd0, 32'h8765_43F1);
    preload(8'd1, 32'h1122_3344);
    preload(8'd2, 32'h1234_5678);
    preload(8'd255, 32'hCAFE_F00D);

    // loads with extension
    send(1'b0, F3_B,  32'h1, '0, 1'b1, 1'b0, 32'h0000_0043); recv("lb_1", 0, 1'b0);
    send(1'b0, F3_B,  32'h0, '0, 1'b1, 1'b0, 32'hFFFF_FFF1); recv("lb_0", 0, 1'b0);
    send(1'b0, F3_BU, 32'h0, '0, 1'b1, 1'b0, 32'h0000_00F1); recv("lbu_0", 0, 1'b0);
    send(1'b0, F3_H,  32'h2, '0, 1'b1, 1'b0, 32'hFFFF_8765); recv("lh_2", 0, 1'b0);
    send(1'b0, F3_HU, 32'h2, '0, 1'b1, 1'b0, 32'h0000_8765); recv("lhu_2", 0, 1'b0);
    send(1'b0, F3_BU, 32'h3, '0, 1'b1, 1'b0, 32'h0000_0087); recv("lbu_3", 0, 1'b0);
    send(1'b0, F3_W,  32'h3FC, '0, 1'b1, 1'b0, 32'hCAFE_F00D); recv("lw_top", 0, 1'b0);

    // sub-word stores
    w0 = we_cnt;
    send(1'b1, F3_B, 32'h6, 32'h0000_00AA, 1'b1, 1'b0, 32'h0); recv("sb_6", 0, 1'b0);
    chk("sb_we_cycles", 32'(we_cnt - w0), 32'd1);
    chk("sb_ram_d", last_d, 32'h11AA_3344);
    chk("sb_mem", mem[1], 32'h11AA_3344);
    w0 = we_cnt;
    send(1'b1, F3_H, 32'h4, 32'h0000_BEEF, 1'b1, 1'b0, 32'h0); recv("sh_4", 0, 1'b0);
    chk("sh_we_cycles", 32'(we_cnt - w0), 32'd1);
    chk("sh_ram_d", last_d, 32'h11AA_BEEF);
    send(1'b0, F3_W, 32'h4, '0, 1'b1, 1'b0, 32'h11AA_BEEF); recv("lw_4", 0, 1'b0);

    // error cases: no write, rdata forced to zero
    w0 = we_cnt;
    send(1'b0, F3_W, 32'h2, '0, 1'b1, 1'b1, 32'h0); recv("lw_mis", 0, 1'b0);
    send(1'b1, F3_H, 32'h5, 32'h0000_5555, 1'b1, 1'b1, 32'h0); recv("sh_mis", 0, 1'b0);
    send(1'b1, 3'b100, 32'h8, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0); recv("st_f3", 0, 1'b0);
    send(1'b0, 3'b011, 32'h0, '0, 1'b1, 1'b1, 32'h0); recv("ld_f3", 0, 1'b0);
    send(1'b0, F3_W, 32'h400, '0, 1'b1, 1'b1, 32'h0); recv("lw_range", 0, 1'b0);
    send(1'b1, F3_W, 32'h400, 32'h1, 1'b1, 1'b1, 32'h0); recv("sw_range", 0, 1'b0);
    chk("err_no_write", 32'(we_cnt - w0), 32'd0);
    chk("err_mem1", mem[1], 32'h11AA_BEEF);
    chk("err_mem2", mem[2], 32'h1234_5678);

    // non-zero base
    b_access("b_below_base", 32'h0000_0FFC, 1'b1, 32'h3FFF_FFFF, 32'h0);
    b_access("b_in_range", 32'h0000_1004, 1'b0, 32'h1, 32'h0BAD_F00D);
    b_access("b_past_end", 32'h0000_1400, 1'b1, 32'h100, 32'h0);

    // response stall with an ignored request pulse
    w0 = we_cnt;
    send(1'b0, F3_W, 32'h0, '0, 1'b1, 1'b0, 32'h8765_43F1); recv("lw_hold", 5, 1'b1);
    @(negedge clk);
    chk("hold_no_extra_resp", {31'h0, resp_valid}, 32'h0);
    chk("hold_state_idle", 32'(dbg_state), 32'(IDLE));
    chk("hold_no_write", 32'(we_cnt - w0), 32'd0);
    chk("hold_mem0", mem[0], 32'h8765_43F1);
    chk("hold_queue_empty", 32'(exp_q.size()), 32'd0);

    // reset during the ACCESS cycle of a store
    w0 = we_cnt;
    send(1'b1, F3_W, 32'h8, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ram_we", {31'h0, ram_we}, 32'h0);
    chk("mid_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_mem2", mem[2], 32'h1234_5678);
    chk("mid_rst_no_write", 32'(we_cnt - w0), 32'd0);
    chk("mid_rst_resp_after", {31'h0, resp_valid}, 32'h0);
    chk("mid_rst_ready_after", {31'h0, req_ready}, 32'h1);
    send(1'b0, F3_W, 32'h8, '0, 1'b1, 1'b0, 32'h1234_5678); recv("lw_after_rst", 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
